// File: rtl/gat_pkg.sv
// gat_pkg: shared widths and the feature-reader state encoding
package gat_pkg;
  localparam int NEW_FEATURE_WIDTH  = 8;
  localparam int NEW_FEATURE_ADDR_W = 12;
  localparam int FEAT_RD_LEN_W      = NEW_FEATURE_ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} feat_rd_state_e;
endpackage

// File: rtl/feat_rd_skid_buf.sv
// feat_rd_skid_buf: 2-entry register FIFO (clk, rst, push/din in, pop in, head/cnt out), head always in slot 0
module feat_rd_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   cnt
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
  always_comb begin
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    head_d = (pop && cnt_q == 2'd2) ? tail_q :
             (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? din : head_q;
    tail_d = (push && (cnt_q == 2'd2 || (cnt_q == 2'd1 && !pop))) ? din : tail_q;
  end
  assign head = head_q;
  assign cnt  = cnt_q;
endmodule

// File: rtl/feat_bram_reader.sv
// feat_bram_reader: streams len BRAM words from base_addr (start/base_addr/len in, addrb out, dout in) as m_t* with busy/done
module feat_bram_reader
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH = NEW_FEATURE_WIDTH,
  parameter int ADDR_W     = NEW_FEATURE_ADDR_W,
  parameter int LEN_W      = FEAT_RD_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LEN_W-1:0]      len,
  output logic [ADDR_W-1:0]     feat_bram_addrb,
  input  logic [DATA_WIDTH-1:0] feat_bram_dout,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  done
);
  feat_rd_state_e    state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]  issue_rem_q, issue_rem_d, beat_rem_q, beat_rem_d;
  logic              inflight_q, issue, pop, start_ok;
  logic [1:0]        buf_cnt, occ;
  feat_rd_skid_buf #(.W(DATA_WIDTH)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .pop  (pop),
    .din  (feat_bram_dout),
    .head (m_tdata),
    .cnt  (buf_cnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      issue_rem_q <= '0;
      beat_rem_q  <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      issue_rem_q <= issue_rem_d;
      beat_rem_q  <= beat_rem_d;
      inflight_q  <= issue;
    end
  end
  assign pop      = m_tvalid && m_tready;
  assign start_ok = state_q == IDLE && start;
  assign occ      = buf_cnt + {1'b0, inflight_q} - {1'b0, pop};
  // rd_addr is the address the BRAM samples on the issuing edge, so addrb is rd_addr itself
  assign issue       = state_q == READ && issue_rem_q != '0 && occ < 2'd2;
  assign rd_addr_d   = start_ok ? base_addr : issue ? rd_addr_q + 1'b1 : rd_addr_q;
  assign issue_rem_d = start_ok ? len : issue ? issue_rem_q - 1'b1 : issue_rem_q;
  assign beat_rem_d  = start_ok ? len : pop ? beat_rem_q - 1'b1 : beat_rem_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : READ;
      READ:    if (issue && issue_rem_q == LEN_W'(1)) state_d = DRAIN;
      DRAIN:   if (beat_rem_d == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    feat_bram_addrb = rd_addr_q;
    m_tvalid        = buf_cnt != 2'd0;
    m_tlast         = m_tvalid && beat_rem_q == LEN_W'(1);
    busy            = state_q != IDLE;
    done            = state_q == DONE;
  end
endmodule

// File: tb/tb_feat_bram_reader.sv
// tb_feat_bram_reader: directed tests of feat_bram_reader against a 1-cycle BRAM model holding mem[i]=i
module tb_feat_bram_reader;
  logic        clk = 0, rst = 1, start = 0, tready = 0;
  logic [11:0] base_addr = 0, addrb, xfer_base = 0;
  logic [12:0] len = 0;
  logic [7:0]  dout, tdata;
  logic        tvalid, tlast, busy, done;
  logic [7:0]  mem [4096];
  logic [7:0]  got_data [16];
  logic        got_last [16];
  int checks = 0, errors = 0;
  int got_n, first_valid, last_beat, done_cyc, stall_bad, ahead_bad, lasts;
  logic done_after, busy_after, valid_after, done_busy;

  always #5 clk = ~clk;
  always @(posedge clk) dout <= mem[addrb];

  feat_bram_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .feat_bram_addrb(addrb), .feat_bram_dout(dout),
    .m_tdata(tdata), .m_tvalid(tvalid), .m_tready(tready), .m_tlast(tlast),
    .busy(busy), .done(done)
  );

  task automatic kick(input logic [11:0] b, input logic [12:0] l);
    @(negedge clk);
    start = 1; base_addr = b; len = l; xfer_base = b;
  endtask

  task automatic collect(input int n_stop, input int mode, input int restart_at);
    logic prev_stall = 0;
    logic [7:0] prev_data = 0;
    logic [11:0] issued;
    got_n = 0; first_valid = -1; last_beat = -1; done_cyc = -1; stall_bad = 0; ahead_bad = 0; lasts = 0;
    done_after = 1; busy_after = 1; valid_after = 1; done_busy = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (cyc == restart_at) begin base_addr = 100; len = 2; end
      tready = (mode == 0) ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
      if (prev_stall && (!tvalid || tdata !== prev_data)) stall_bad++;
      issued = addrb - xfer_base;
      if (int'(issued) - got_n > 2) ahead_bad++;
      if (done_cyc >= 0) begin
        done_after = done; busy_after = busy; valid_after = tvalid;
        break;
      end
      if (done) begin done_cyc = cyc; done_busy = busy; end
      if (tvalid && first_valid < 0) first_valid = cyc;
      if (tvalid && tready) begin
        if (got_n < 16) begin got_data[got_n] = tdata; got_last[got_n] = tlast; end
        got_n++; last_beat = cyc;
        if (tlast) lasts++;
      end
      prev_stall = tvalid && !tready; prev_data = tdata;
      if (n_stop > 0 && got_n == n_stop) break;
    end
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({addrb, tdata, tvalid, tlast, busy, done} !== 24'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 000000", {addrb, tdata, tvalid, tlast, busy, done});
    end
    rst = 0;
  endtask

  task automatic test_stream;
    kick(0, 8); collect(0, 0, -1);
    checks++; if (got_n !== 8) begin errors++; $display("FAIL stream_count got %0d exp 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_data[i] !== 8'(i)) begin errors++; $display("FAIL stream_data[%0d] got %0d exp %0d", i, got_data[i], i); end
    end
    checks++; if (first_valid !== 2) begin errors++; $display("FAIL stream_first_valid got %0d exp 2", first_valid); end
    checks++; if (last_beat !== first_valid + 7) begin errors++; $display("FAIL stream_contiguous got %0d exp %0d", last_beat, first_valid + 7); end
    checks++; if (lasts !== 1 || got_last[7] !== 1'b1) begin errors++; $display("FAIL stream_tlast got %0d/%b exp 1/1", lasts, got_last[7]); end
    checks++; if (done_cyc !== last_beat + 1) begin errors++; $display("FAIL stream_done_cycle got %0d exp %0d", done_cyc, last_beat + 1); end
    checks++; if ({done_after, busy_after, valid_after} !== 3'b000) begin errors++; $display("FAIL stream_after_done got %b exp 000", {done_after, busy_after, valid_after}); end
  endtask

  task automatic test_back_to_back;
    start = 1; base_addr = 10; len = 2; xfer_base = 10;
    collect(0, 0, -1);
    checks++; if (first_valid !== 2) begin errors++; $display("FAIL b2b_first_valid got %0d exp 2", first_valid); end
    checks++; if (got_n !== 2 || got_data[0] !== 8'd10 || got_data[1] !== 8'd11) begin
      errors++; $display("FAIL b2b_data got n=%0d %0d,%0d exp n=2 10,11", got_n, got_data[0], got_data[1]);
    end
  endtask

  task automatic test_backpressure;
    kick(0, 8); collect(0, 1, -1);
    checks++; if (got_n !== 8) begin errors++; $display("FAIL bp_count got %0d exp 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_data[i] !== 8'(i)) begin errors++; $display("FAIL bp_data[%0d] got %0d exp %0d", i, got_data[i], i); end
    end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stable got %0d exp 0", stall_bad); end
    checks++; if (ahead_bad !== 0) begin errors++; $display("FAIL bp_ahead got %0d exp 0", ahead_bad); end
    checks++; if (lasts !== 1 || got_last[7] !== 1'b1) begin errors++; $display("FAIL bp_tlast got %0d/%b exp 1/1", lasts, got_last[7]); end
    checks++; if (done_cyc !== last_beat + 1) begin errors++; $display("FAIL bp_done_cycle got %0d exp %0d", done_cyc, last_beat + 1); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_w [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    kick(4094, 4); collect(0, 0, -1);
    checks++; if (got_n !== 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== exp_w[i]) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, got_data[i], exp_w[i]); end
    end
    checks++; if (lasts !== 1 || got_last[3] !== 1'b1) begin errors++; $display("FAIL wrap_tlast got %0d/%b exp 1/1", lasts, got_last[3]); end
  endtask

  task automatic test_len0;
    kick(0, 0); collect(0, 0, -1);
    checks++; if (done_cyc !== 0) begin errors++; $display("FAIL len0_done_cycle got %0d exp 0", done_cyc); end
    checks++; if (first_valid !== -1 || got_n !== 0) begin errors++; $display("FAIL len0_no_beats got %0d/%0d exp -1/0", first_valid, got_n); end
    checks++; if ({done_busy, busy_after, done_after} !== 3'b100) begin errors++; $display("FAIL len0_busy got %b exp 100", {done_busy, busy_after, done_after}); end
  endtask

  task automatic test_restart_ignored;
    kick(0, 8); collect(0, 0, 4);
    checks++; if (got_n !== 8) begin errors++; $display("FAIL restart_count got %0d exp 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_data[i] !== 8'(i)) begin errors++; $display("FAIL restart_data[%0d] got %0d exp %0d", i, got_data[i], i); end
    end
    checks++; if (valid_after !== 1'b0 || busy_after !== 1'b0) begin errors++; $display("FAIL restart_idle got %b%b exp 00", valid_after, busy_after); end
  endtask

  task automatic test_midreset;
    int bad = 0;
    kick(0, 8); collect(3, 0, -1);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    checks++;
    if ({addrb, tdata, tvalid, tlast, busy, done} !== 24'h0) begin
      errors++; $display("FAIL midreset_outputs got %h exp 000000", {addrb, tdata, tvalid, tlast, busy, done});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || tvalid || busy) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_quiet got %0d exp 0", bad); end
    kick(0, 2); collect(0, 0, -1);
    checks++; if (got_n !== 2 || got_data[0] !== 8'd0 || got_data[1] !== 8'd1 || got_last[1] !== 1'b1) begin
      errors++; $display("FAIL midreset_restart got n=%0d %0d,%0d exp n=2 0,1", got_n, got_data[0], got_data[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
    test_reset;
    test_stream;
    test_back_to_back;
    test_backpressure;
    test_wrap;
    test_len0;
    test_restart_ignored;
    test_midreset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
